// File: rtl/axi_mem_pattern_chk_if.sv
// -----------------------------------------------------------------------------
// axi_mem_pattern_chk_if
// AXI4 bus bundle between the pattern checker (master) and a memory slave.
// Only the signals the checker actually drives or samples are carried.
//
// Parameters:
//   DATA_W  AXI data width in bits
//   ADDR_W  AXI address width in bits
//
// Modports:
//   master  drives AW/W/AR payload + valids, BREADY/RREADY; samples the rest
//   slave   mirror of master
// -----------------------------------------------------------------------------
interface axi_mem_pattern_chk_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 44
);
    // AW channel
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    // W channel
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    // B channel
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    // AR channel
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    // R channel
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_mem_pattern_chk.sv
// -----------------------------------------------------------------------------
// axi_mem_pattern_chk
// AXI4 master that fills a memory region with an address-as-data pattern
// (32-bit lane k of the beat at byte address A holds A + 4k) and/or reads the
// region back and counts miscompared lanes. One burst outstanding at a time.
//
// Ports:
//   ACLK, ARESET    clock; synchronous active-high reset (aborts a run)
//   start_i         1-cycle start pulse, ignored unless idle
//   mode_i          0 write, 1 check, 2/3 write then check
//   base_addr_i     region start (burst aligned)
//   xfer_bytes_i    region length (multiple of one burst)
//   busy_o          run in progress
//   done_o          1-cycle completion pulse
//   pass_o          no miscompares and no response errors (valid from done)
//   err_count_o     saturating count of miscompared 32-bit lanes
//   resp_err_o      sticky: bad BRESP/RRESP or misplaced RLAST
//   m_axi           AXI4 master port
//
// Optional feature macro AXI_PATCHK_FAIL_CAPTURE_EN adds fail_addr_o,
// fail_data_o and fail_valid_o, holding the address and RDATA of the first
// miscompared beat of a run.
// -----------------------------------------------------------------------------
module axi_mem_pattern_chk #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 44,
    parameter int BURST_LEN = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [31:0]           xfer_bytes_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [15:0]           err_count_o,
    output logic                  resp_err_o,
    axi_mem_pattern_chk_if.master m_axi
`ifdef AXI_PATCHK_FAIL_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0]     fail_addr_o,
    output logic [DATA_W-1:0]     fail_data_o,
    output logic                  fail_valid_o
`endif
);

    localparam int BEAT_BYTES  = DATA_W / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int LANES       = DATA_W / 32;
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(BURST_LEN - 1);
    localparam logic [31:0]       BEAT_INC32   = 32'(BEAT_BYTES);
    localparam logic [31:0]       BURST_BYTES32 = 32'(BURST_BYTES);
    localparam logic [ADDR_W-1:0] BURST_INC    = ADDR_W'(BURST_BYTES);

    typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, FIN} state_t;

    // Expected beat contents; only the low 32 address bits take part.
    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] a);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int k = 0; k < LANES; k++) p[32*k +: 32] = a + 32'(4 * k);
        return p;
    endfunction

    function automatic logic [16:0] miss_count(input logic [DATA_W-1:0] data,
                                               input logic [31:0]       a);
        logic [DATA_W-1:0] exp;
        logic [16:0]       n;
        exp = pattern(a);
        n   = '0;
        for (int k = 0; k < LANES; k++)
            if (data[32*k +: 32] != exp[32*k +: 32]) n = n + 17'd1;
        return n;
    endfunction

    state_t            state_q, state_d;
    logic              chk_after_wr_q, chk_after_wr_d;   // mode 2/3
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       xfer_q, xfer_d;
    logic [31:0]       rem_q, rem_d;          // bytes left incl. current burst
    logic [ADDR_W-1:0] addr_q, addr_d;        // current burst address
    logic [31:0]       beat_addr_q, beat_addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [15:0]       err_q, err_d;
    logic              resp_err_q, resp_err_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
`ifdef AXI_PATCHK_FAIL_CAPTURE_EN
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic              fail_valid_q, fail_valid_d;
`endif

    logic [16:0] lane_miss;
    logic [16:0] err_sum;
    logic        last_beat;
    logic        last_burst;

    assign lane_miss  = miss_count(m_axi.rdata, beat_addr_q);
    assign err_sum    = 17'(err_q) + lane_miss;
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (rem_q == BURST_BYTES32);

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no
        // path through the case can leave one unassigned and infer a latch.
        state_d        = state_q;
        chk_after_wr_d = chk_after_wr_q;
        base_d         = base_q;
        xfer_d         = xfer_q;
        rem_d          = rem_q;
        addr_d         = addr_q;
        beat_addr_d    = beat_addr_q;
        beat_d         = beat_q;
        err_d          = err_q;
        resp_err_d     = resp_err_q;
        pass_d         = pass_q;
        done_d         = 1'b0;
`ifdef AXI_PATCHK_FAIL_CAPTURE_EN
        fail_addr_d    = fail_addr_q;
        fail_data_d    = fail_data_q;
        fail_valid_d   = fail_valid_q;
`endif

        unique case (state_q)
            IDLE: if (start_i) begin
                chk_after_wr_d = mode_i[1];
                base_d         = base_addr_i;
                xfer_d         = xfer_bytes_i;
                rem_d          = xfer_bytes_i;
                addr_d         = base_addr_i;
                err_d          = '0;
                resp_err_d     = 1'b0;
                pass_d         = 1'b0;
`ifdef AXI_PATCHK_FAIL_CAPTURE_EN
                fail_addr_d    = '0;
                fail_data_d    = '0;
                fail_valid_d   = 1'b0;
`endif
                if (xfer_bytes_i == 32'd0) state_d = FIN;
                else if (mode_i == 2'd1)   state_d = RD_AR;
                else                       state_d = WR_AW;
            end
            WR_AW: if (awvalid_q && m_axi.awready) begin
                state_d     = WR_W;
                beat_d      = '0;
                beat_addr_d = 32'(addr_q);
            end
            WR_W: if (wvalid_q && m_axi.wready) begin
                beat_addr_d = beat_addr_q + BEAT_INC32;
                if (last_beat) state_d = WR_B;
                else           beat_d  = beat_q + BEAT_W'(1);
            end
            WR_B: if (bready_q && m_axi.bvalid) begin
                if (m_axi.bresp != 2'b00) resp_err_d = 1'b1;
                if (!last_burst) begin
                    rem_d   = rem_q - BURST_BYTES32;
                    addr_d  = addr_q + BURST_INC;
                    state_d = WR_AW;
                end else if (chk_after_wr_q) begin
                    // Read-back pass walks the whole region again.
                    rem_d   = xfer_q;
                    addr_d  = base_q;
                    state_d = RD_AR;
                end else begin
                    state_d = FIN;
                end
            end
            RD_AR: if (arvalid_q && m_axi.arready) begin
                state_d     = RD_R;
                beat_d      = '0;
                beat_addr_d = 32'(addr_q);
            end
            RD_R: if (rready_q && m_axi.rvalid) begin
                err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
                // Burst end is tracked by our own beat count; RLAST is only checked.
                if (m_axi.rresp != 2'b00 || m_axi.rlast != last_beat) resp_err_d = 1'b1;
`ifdef AXI_PATCHK_FAIL_CAPTURE_EN
                if (lane_miss != 17'd0 && !fail_valid_q) begin
                    // Bursts never cross 4 KB, so the upper address bits
                    // of the beat equal those of the burst address.
                    fail_addr_d  = (addr_q & ~ADDR_W'(32'hFFFF_FFFF)) | ADDR_W'(beat_addr_q);
                    fail_data_d  = m_axi.rdata;
                    fail_valid_d = 1'b1;
                end
`endif
                beat_addr_d = beat_addr_q + BEAT_INC32;
                if (!last_beat) begin
                    beat_d = beat_q + BEAT_W'(1);
                end else if (!last_burst) begin
                    rem_d   = rem_q - BURST_BYTES32;
                    addr_d  = addr_q + BURST_INC;
                    state_d = RD_AR;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // done/pass are produced on the edge that enters FIN, whatever path led there.
        if (state_d == FIN && state_q != FIN) begin
            done_d = 1'b1;
            pass_d = (err_d == 16'd0) && !resp_err_d;
        end
    end

    always_ff @(posedge ACLK) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (ARESET) begin
            state_q        <= IDLE;
            chk_after_wr_q <= 1'b0;
            base_q         <= '0;
            xfer_q         <= '0;
            rem_q          <= '0;
            addr_q         <= '0;
            beat_addr_q    <= '0;
            beat_q         <= '0;
            err_q          <= '0;
            resp_err_q     <= 1'b0;
            pass_q         <= 1'b0;
            done_q         <= 1'b0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            wlast_q        <= 1'b0;
            bready_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
`ifdef AXI_PATCHK_FAIL_CAPTURE_EN
            fail_addr_q    <= '0;
            fail_data_q    <= '0;
            fail_valid_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            chk_after_wr_q <= chk_after_wr_d;
            base_q         <= base_d;
            xfer_q         <= xfer_d;
            rem_q          <= rem_d;
            addr_q         <= addr_d;
            beat_addr_q    <= beat_addr_d;
            beat_q         <= beat_d;
            err_q          <= err_d;
            resp_err_q     <= resp_err_d;
            pass_q         <= pass_d;
            done_q         <= done_d;
            // Handshake outputs are flops decoded from the next state.
            awvalid_q      <= (state_d == WR_AW);
            wvalid_q       <= (state_d == WR_W);
            wlast_q        <= (state_d == WR_W) && (beat_d == LAST_BEAT);
            bready_q       <= (state_d == WR_B);
            arvalid_q      <= (state_d == RD_AR);
            rready_q       <= (state_d == RD_R);
`ifdef AXI_PATCHK_FAIL_CAPTURE_EN
            fail_addr_q    <= fail_addr_d;
            fail_data_q    <= fail_data_d;
            fail_valid_q   <= fail_valid_d;
`endif
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign err_count_o   = err_q;
    assign resp_err_o    = resp_err_q;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = 8'(BURST_LEN - 1);
    assign m_axi.awsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = pattern(beat_addr_q);
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = wlast_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = 8'(BURST_LEN - 1);
    assign m_axi.arsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi.arburst = 2'b01;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

`ifdef AXI_PATCHK_FAIL_CAPTURE_EN
    assign fail_addr_o   = fail_addr_q;
    assign fail_data_o   = fail_data_q;
    assign fail_valid_o  = fail_valid_q;
`endif

endmodule
